fir_tap_mac: RTL and testbench



---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_sample_ram.sv | 37 +++
 rtl/fir_tap_mac.sv | 184 ++++++++++++++++++
 tb/tb_fir_tap_mac.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, types and the rounding constant for the FIR tap MAC datapath.
// No logic of its own; every user picks up widths and helpers from here.
// No backpressure: pure declarations.
package fir_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ACC_W_DEF  = 48;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic signed [COEF_W_DEF-1:0] coef_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  // Half-LSB of the Q1.(coef_w-1) product scaling, used for half-up rounding.
  function automatic longint rnd_const(input int coef_w);
    return longint'(1) << (coef_w - 2);
  endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Sample RAM: one write port, one synchronous read-first read port.
// Latency: read data registered one cycle after rd_en; not cleared by reset.
// No backpressure: accepts a read and a write every cycle.
module fir_sample_ram
  import fir_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read the array before this cycle's write lands, so a same-address write returns old data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Array write and read register; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_tap_mac.sv
// FIR tap multiply-accumulate: reads coef/sample, multiplies, accumulates per frame, rounds out.
// Latency: tap_last at t -> y_valid at t+4; one tap per cycle. Macro FIR_TAP_MAC_SAT_EN enables clamping.
// No backpressure: bubbles (rd_en=0) simply flow through as invalid slots.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int COEF_W       = COEF_W_DEF,
  parameter int ACC_W        = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [H_ADDR_WIDTH-1:0] h_addr,
  input  logic [X_ADDR_WIDTH-1:0] x_addr,
  input  logic                    tap_last,
  input  logic                    x_wr_en,
  input  logic [X_ADDR_WIDTH-1:0] x_wr_addr,
  input  logic [DATA_W-1:0]       x_wr_data,
  input  logic                    h_wr_en,
  input  logic [H_ADDR_WIDTH-1:0] h_wr_addr,
  input  logic [COEF_W-1:0]       h_wr_data,
  output logic [DATA_W-1:0]       y_out,
  output logic                    y_valid,
  output logic                    sat_hit
);

  localparam int NTAPS  = 2**H_ADDR_WIDTH;
  localparam int PROD_W = COEF_W + DATA_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(rnd_const(COEF_W));

  // Coefficient register file
  logic [COEF_W-1:0] coef_q [NTAPS];
  logic [COEF_W-1:0] coef_d [NTAPS];

  // R stage
  logic              vld_r_q, vld_r_d, last_r_q, last_r_d;
  logic [COEF_W-1:0] h_r_q, h_r_d;
  logic [DATA_W-1:0] x_r_dat;

  // M stage
  logic                     vld_m_q, vld_m_d, last_m_q, last_m_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;

  // P stage
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d, last_p_q, last_p_d;
  logic signed [ACC_W-1:0] prod_ext;

  // O stage
  logic [DATA_W-1:0]       y_out_q, y_out_d;
  logic                    y_valid_q, y_valid_d;
  logic signed [ACC_W-1:0] r_sum, r;

  // Coefficient writes land at the clock edge, so a read in the same cycle sees the old value.
  always_comb begin
    coef_d = coef_q;
    if (h_wr_en) coef_d[h_wr_addr] = h_wr_data;
  end

  // Coefficient storage is not cleared by reset.
  always_ff @(posedge clk) begin
    coef_q <= coef_d;
  end

  fir_sample_ram #(
    .ADDR_W (X_ADDR_WIDTH),
    .DATA_W (DATA_W)
  ) u_sample_ram (
    .clk     (clk),
    .wr_en   (x_wr_en),
    .wr_addr (x_wr_addr),
    .wr_data (x_wr_data),
    .rd_en   (rd_en),
    .rd_addr (x_addr),
    .rd_data (x_r_dat)
  );

  // Pipeline next-state: flags ride with data, products only update on valid slots.
  always_comb begin
    vld_r_d  = rd_en;
    last_r_d = rd_en & tap_last;
    h_r_d    = rd_en ? coef_q[h_addr] : h_r_q;

    vld_m_d  = vld_r_q;
    last_m_d = last_r_q;
    prod_d   = prod_q;
    if (vld_r_q) prod_d = PROD_W'($signed(h_r_q)) * PROD_W'($signed(x_r_dat));

    prod_ext = ACC_W'(prod_q);
    acc_d    = acc_q;
    first_d  = first_q;
    last_p_d = vld_m_q & last_m_q;
    if (vld_m_q) begin
      acc_d   = first_q ? prod_ext : acc_q + prod_ext;
      first_d = last_m_q;
    end
  end

  // Pipeline registers; only control state is reset, data regs are qualified by vld.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r_q  <= 1'b0;
      last_r_q <= 1'b0;
      vld_m_q  <= 1'b0;
      last_m_q <= 1'b0;
      acc_q    <= '0;
      first_q  <= 1'b1;
      last_p_q <= 1'b0;
    end else begin
      vld_r_q  <= vld_r_d;
      last_r_q <= last_r_d;
      vld_m_q  <= vld_m_d;
      last_m_q <= last_m_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
      last_p_q <= last_p_d;
    end
    h_r_q  <= h_r_d;
    prod_q <= prod_d;
  end

  assign r_sum = acc_q + RND;
  assign r     = r_sum >>> (COEF_W - 1);

`ifdef FIR_TAP_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - 1;

  logic sat_q, sat_d;

  // Output narrowing with clamp; any clamp sets the sticky flag.
  always_comb begin
    y_out_d   = y_out_q;
    y_valid_d = last_p_q;
    sat_d     = sat_q;
    if (last_p_q) begin
      if (r > Y_MAX) begin
        y_out_d = {1'b0, {(DATA_W-1){1'b1}}};
        sat_d   = 1'b1;
      end else if (r < Y_MIN) begin
        y_out_d = {1'b1, {(DATA_W-1){1'b0}}};
        sat_d   = 1'b1;
      end else begin
        y_out_d = DATA_W'(r);
      end
    end
  end

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_hit = sat_q;
`else
  // Output narrowing by plain truncation (wraps on overflow).
  always_comb begin
    y_out_d   = y_out_q;
    y_valid_d = last_p_q;
    if (last_p_q) y_out_d = DATA_W'(r);
  end

  assign sat_hit = 1'b0;
`endif

  // Output register: y_out holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Scoreboard bench for fir_tap_mac: stimulus pushes expected strobes, a negedge monitor checks them.
// Expected values are hand-computed for 16-tap frames at default widths.
// Drives inputs #1 after posedge; samples outputs on negedge.
module tb_fir_tap_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  h_addr = '0;
  logic [5:0]  x_addr = '0;
  logic        tap_last = 1'b0;
  logic        x_wr_en = 1'b0;
  logic [5:0]  x_wr_addr = '0;
  logic [15:0] x_wr_data = '0;
  logic        h_wr_en = 1'b0;
  logic [3:0]  h_wr_addr = '0;
  logic [15:0] h_wr_data = '0;
  logic [15:0] y_out;
  logic        y_valid;
  logic        sat_hit;

  fir_tap_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .h_addr    (h_addr),
    .x_addr    (x_addr),
    .tap_last  (tap_last),
    .x_wr_en   (x_wr_en),
    .x_wr_addr (x_wr_addr),
    .x_wr_data (x_wr_data),
    .h_wr_en   (h_wr_en),
    .h_wr_addr (h_wr_addr),
    .h_wr_data (h_wr_data),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .sat_hit   (sat_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

`ifdef FIR_TAP_MAC_SAT_EN
  localparam logic [15:0] SAT_Y = 16'h7FFF;
  localparam logic        SAT_F = 1'b1;
`else
  localparam logic [15:0] SAT_Y = 16'hFFE0;
  localparam logic        SAT_F = 1'b0;
`endif

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_hold = '0;
  bit          rst_low_prev = 1'b0;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: reset-state checks, strobe scoreboard, hold checks, final drain and summary.
  always @(negedge clk) begin
    if (done) begin
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end else begin
      if (y_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y_out", y_out, e.y);
          chk("strobe_cycle", cyc, e.cyc);
          chk("sat_hit", sat_hit, e.sat);
          exp_hold = e.y;
        end
      end else if (!rst_n) begin
        if (rst_low_prev) begin
          chk("rst_y_out", y_out, 0);
          chk("rst_y_valid", y_valid, 0);
          chk("rst_sat_hit", sat_hit, 0);
        end
        exp_hold = '0;
      end else begin
        chk("y_hold", y_out, exp_hold);
      end
      rst_low_prev = !rst_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en    = 1'b0;
    tap_last = 1'b0;
    x_wr_en  = 1'b0;
    h_wr_en  = 1'b0;
  endtask

  task automatic load(input logic [15:0] hv, input logic [15:0] xv);
    for (int i = 0; i < 16; i++) begin
      h_wr_en = 1'b1; h_wr_addr = i[3:0]; h_wr_data = hv;
      x_wr_en = 1'b1; x_wr_addr = i[5:0]; x_wr_data = xv;
      step();
    end
    idle();
  endtask

  task automatic issue_tap(input int i, input bit last);
    rd_en = 1'b1; h_addr = i[3:0]; x_addr = i[5:0]; tap_last = last;
  endtask

  // One 16-tap frame; optional bubbles between taps and an x[5] write during its read.
  task automatic frame(input bit bubbles, input bit rdw, input logic [15:0] ey, input logic es);
    for (int i = 0; i < 16; i++) begin
      issue_tap(i, i == 15);
      if (rdw && i == 5) begin
        x_wr_en = 1'b1; x_wr_addr = 6'd5; x_wr_data = 16'h0200;
      end
      if (i == 15) exp_q.push_back('{y: ey, sat: es, cyc: cyc + 4});
      step();
      x_wr_en = 1'b0;
      if (bubbles && i != 15) begin
        idle();
        step();
      end
    end
    idle();
  endtask

  task automatic drain();
    repeat (8) step();
  endtask

  initial begin
    // Power-on reset with outputs checked by the monitor.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    load(16'h4000, 16'h0100);

    // Reset for 2 cycles in the middle of traffic, then one complete frame.
    for (int i = 0; i < 4; i++) begin issue_tap(i, 1'b0); step(); end
    rst_n = 1'b0;
    for (int i = 4; i < 6; i++) begin issue_tap(i, 1'b0); step(); end
    rst_n = 1'b1;
    idle();
    repeat (3) step();
    frame(1'b0, 1'b0, 16'h0800, 1'b0);
    drain();

    // Basic frame, then the same data with bubbles.
    frame(1'b0, 1'b0, 16'h0800, 1'b0);
    drain();
    frame(1'b1, 1'b0, 16'h0800, 1'b0);
    drain();

    // Two contiguous frames.
    frame(1'b0, 1'b0, 16'h0800, 1'b0);
    frame(1'b0, 1'b0, 16'h0800, 1'b0);
    drain();

    // Reset after 8 taps, then a full frame.
    for (int i = 0; i < 8; i++) begin issue_tap(i, 1'b0); step(); end
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    frame(1'b0, 1'b0, 16'h0800, 1'b0);
    drain();

    // Read-during-write on x[5]: old data this frame, new data next frame.
    frame(1'b0, 1'b1, 16'h0800, 1'b0);
    frame(1'b0, 1'b0, 16'h0880, 1'b0);
    drain();

    // Full-scale frame: clamps or wraps depending on build.
    load(16'h7FFF, 16'h7FFF);
    frame(1'b0, 1'b0, SAT_Y, SAT_F);
    drain();

    done = 1'b1;
  end

endmodule
